// File: rtl/arb_pkg.sv
// Shared types for the round-robin / fixed-priority arbiter: FSM state encoding
// and mode constants.
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/pri_enc_n.sv
// Combinational wrapping priority search: checks start-1, start-2 .. 0, N-1 .. start
// and returns the first set request.
module pri_enc_n #(
  parameter  int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic         found,
  output logic [W-1:0] idx
);

  int cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int i = 1; i <= N; i++) begin
      cand = (int'(start) + N - i) % N;
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand[W-1:0];
      end
    end
  end

endmodule

// File: rtl/rr_pri_arbiter.sv
// N-request arbiter with registered grant and valid/ready handshake; runtime fixed or
// round-robin priority. Optional burst lock is built when ARB_LOCK_EN is defined.
module rr_pri_arbiter
  import arb_pkg::*;
#(
  parameter  int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         mode,
  input  logic         gnt_ready,
`ifdef ARB_LOCK_EN
  input  logic         lock,
`endif
  output logic         gnt_valid,
  output logic [W-1:0] gnt_idx,
  output logic [N-1:0] gnt_onehot,
  output state_e       state_dbg
);

  // Handshake: a grant transfers on any rising edge where gnt_valid && gnt_ready.
  // gnt_valid never drops until that happens; gnt_ready is ignored while gnt_valid=0.

  state_e       state;
  logic [W-1:0] ptr;
  logic [W-1:0] ptr_next;
  logic [W-1:0] start;
  logic [W-1:0] enc_idx;
  logic [N-1:0] enc_onehot;
  logic         found;
  logic         handshake;
  logic         hold;

  assign handshake = (state == GRANT) && gnt_ready;

`ifdef ARB_LOCK_EN
  assign hold = lock && req[gnt_idx];
`else
  assign hold = 1'b0;
`endif

  // The search for a handshake cycle already sees the just-accepted index as ptr.
  assign ptr_next   = (handshake && !hold) ? gnt_idx : ptr;
  assign start      = (mode == MODE_RR) ? ptr_next : '0;
  assign enc_onehot = {{(N-1){1'b0}}, 1'b1} << enc_idx;
  assign state_dbg  = state;

  pri_enc_n #(.N(N)) u_enc (
    .req   (req),
    .start (start),
    .found (found),
    .idx   (enc_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      gnt_valid  <= 1'b0;
      gnt_idx    <= '0;
      gnt_onehot <= '0;
      ptr        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req != '0) begin
            state      <= GRANT;
            gnt_valid  <= 1'b1;
            gnt_idx    <= enc_idx;
            gnt_onehot <= enc_onehot;
          end
        end
        GRANT: begin
          if (gnt_ready) begin
            ptr <= ptr_next;
            if (!hold) begin
              if (found) begin
                gnt_idx    <= enc_idx;
                gnt_onehot <= enc_onehot;
              end else begin
                state      <= IDLE;
                gnt_valid  <= 1'b0;
                gnt_onehot <= '0;
              end
            end
          end
        end
        default: begin
          state      <= IDLE;
          gnt_valid  <= 1'b0;
          gnt_onehot <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_pri_arbiter.sv
// Bench for rr_pri_arbiter: directed scenarios plus random traffic, scored against
// a rank-based reference model through an expected-value queue.
module tb_rr_pri_arbiter;
  import arb_pkg::*;

  localparam int N  = 4;
  localparam int W  = $clog2(N);
  localparam int EW = 1 + W + N;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req = '0;
  logic         mode = 1'b0;
  logic         gnt_ready = 1'b0;
  logic         lock_r = 1'b0;
  logic         gnt_valid;
  logic [W-1:0] gnt_idx;
  logic [N-1:0] gnt_onehot;
  state_e       state_dbg;

  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rr_pri_arbiter #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .mode       (mode),
    .gnt_ready  (gnt_ready),
`ifdef ARB_LOCK_EN
    .lock       (lock_r),
`endif
    .gnt_valid  (gnt_valid),
    .gnt_idx    (gnt_idx),
    .gnt_onehot (gnt_onehot),
    .state_dbg  (state_dbg)
  );

  // reference model: every requester gets a rank, lowest rank wins
  bit m_valid = 1'b0;
  int m_idx   = 0;
  int m_ptr   = 0;

  function automatic int pick(logic [N-1:0] r, logic rr, int p);
    int best = -1;
    int best_rank = N;
    int rank;
    for (int i = 0; i < N; i++) begin
      if (r[i]) begin
        rank = rr ? ((p - i - 1 + 2 * N) % N) : (N - 1 - i);
        if (rank < best_rank) begin
          best_rank = rank;
          best = i;
        end
      end
    end
    return best;
  endfunction

  function automatic logic [EW-1:0] pack_exp(bit v, int idx);
    logic [W-1:0] i_w;
    logic [N-1:0] oh;
    i_w = idx[W-1:0];
    oh  = v ? (N'(1) << idx) : '0;
    return {v, i_w, oh};
  endfunction

  always @(posedge clk or posedge rst) begin
    bit lk;
    bit hold;
    if (rst) begin
      m_valid = 1'b0;
      m_idx   = 0;
      m_ptr   = 0;
      exp_q.delete();
      exp_q.push_back(pack_exp(1'b0, 0));
    end else begin
`ifdef ARB_LOCK_EN
      lk = lock_r;
`else
      lk = 1'b0;
`endif
      if (!m_valid) begin
        if (req != '0) begin
          m_valid = 1'b1;
          m_idx   = pick(req, mode, m_ptr);
        end
      end else if (gnt_ready) begin
        hold = lk && req[m_idx];
        if (!hold) begin
          m_ptr = m_idx;
          if (req != '0) m_idx = pick(req, mode, m_ptr);
          else m_valid = 1'b0;
        end
      end
      exp_q.push_back(pack_exp(m_valid, m_idx));
    end
  end

  // monitor
  always @(negedge clk) begin
    logic [EW-1:0] e;
    logic          ev;
    logic [W-1:0]  ei;
    logic [N-1:0]  eoh;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      ev  = e[EW-1];
      ei  = e[N +: W];
      eoh = e[N-1:0];
      checks++;
      if (gnt_valid === ev && gnt_onehot === eoh && (!ev || gnt_idx === ei) &&
          ((state_dbg == GRANT) === ev))
        passes++;
      else
        $display("FAIL grant cyc=%0d got v=%0b idx=%0d oh=%b st=%0d want v=%0b idx=%0d oh=%b",
                 cyc, gnt_valid, gnt_idx, gnt_onehot, state_dbg, ev, ei, eoh);
    end
  end

  // driver tasks
  task automatic drive(input logic [N-1:0] r, input logic m, input logic rdy, input logic lk);
    @(negedge clk);
    req       = r;
    mode      = m;
    gnt_ready = rdy;
    lock_r    = lk;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (gnt_valid === 1'b0 && gnt_onehot === '0 && gnt_idx === '0) passes++;
    else $display("FAIL async_reset got v=%0b idx=%0d oh=%b want v=0 idx=0 oh=0000",
                  gnt_valid, gnt_idx, gnt_onehot);
    @(negedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b0;

    // fixed priority first grant
    drive(4'b1010, 1'b0, 1'b0, 1'b0);
    drive(4'b1010, 1'b0, 1'b0, 1'b0);
    drive(4'b1010, 1'b0, 1'b1, 1'b0);
    drive(4'b0000, 1'b0, 1'b1, 1'b0);
    drive(4'b0000, 1'b0, 1'b0, 1'b0);

    // round-robin rotation, back-to-back
    pulse_reset();
    for (int i = 0; i < 7; i++) drive(4'b1111, 1'b1, 1'b1, 1'b0);

    // held grant while requests change
    pulse_reset();
    drive(4'b0100, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) drive(4'b0001, 1'b1, 1'b0, 1'b0);
    drive(4'b0001, 1'b0, 1'b1, 1'b0);
    drive(4'b0000, 1'b0, 1'b0, 1'b0);

    // handshake with no requests, ready pulses in idle
    drive(4'b0000, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) drive(4'b0000, 1'b0, i[0], 1'b0);

    // reset mid-grant, then full request after release
    drive(4'b0010, 1'b1, 1'b0, 1'b0);
    drive(4'b0010, 1'b1, 1'b0, 1'b0);
    pulse_reset();
    drive(4'b1111, 1'b1, 1'b0, 1'b0);
    drive(4'b1111, 1'b1, 1'b1, 1'b0);
    drive(4'b0000, 1'b1, 1'b1, 1'b0);

    // burst lock on index 1
    drive(4'b0010, 1'b1, 1'b0, 1'b0);
    drive(4'b0011, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) drive(4'b0011, 1'b1, 1'b1, 1'b1);
    drive(4'b0011, 1'b1, 1'b1, 1'b0);
    drive(4'b0000, 1'b1, 1'b1, 1'b0);

    // random traffic
    for (int i = 0; i < 800; i++) begin
      logic [N-1:0] r;
      r = ($urandom_range(0, 4) == 0) ? '0 : N'($urandom_range(0, (1 << N) - 1));
      drive(r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) < 6),
            1'($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 199) == 0) pulse_reset();
    end

    drive('0, 1'b0, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
